// File: rtl/nrf2401_spi_shifter_pkg.sv
// Shared definitions for the nRF2401 serial shifter: register map, bit positions, FSM states.
package nrf2401_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CLKDIV  = 2'd3;

    localparam int CTRL_DIR    = 0;
    localparam int CTRL_CS     = 1;
    localparam int CTRL_CE     = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_DONE     = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_WR_ERR   = 4;
    localparam int ST_DR1      = 5;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

endpackage

// File: rtl/nrf2401_spi_shifter_if.sv
// Avalon-MM slave bus bundle between the CPU fabric and the nRF2401 shifter.
interface nrf2401_spi_shifter_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic       read_n;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/nrf2401_spi_shifter_clk_div.sv
// Loadable down-counter: emits a one-cycle tick every (reload+1) cycles while running.
module nrf2401_clk_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] reload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_val;
            reload <= load_val;
        end else if (run) begin
            if (count == '0)
                count <= reload;
            else
                count <= count - DIV_W'(1);
        end
    end

    assign tick = run && (count == '0);

endmodule

// File: rtl/nrf2401_spi_shifter.sv
// nRF2401 three-wire sequencer: Avalon-MM registers plus an MSB-first byte shifter on CLK1/DATA.
module nrf2401_spi_shifter
    import nrf2401_pkg::*;
#(
    parameter int unsigned      DIV_W     = 8,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(4)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nrf2401_spi_shifter_if.slave   bus,
    inout  wire                    rf_data,
    output logic                   rf_clk,
    output logic                   rf_cs,
    output logic                   rf_ce,
    input  logic                   rf_dr1,
    output logic                   irq
);

    state_t           state;
    logic             busy, dir, irq_en;
    logic             rx_valid, done, overrun, wr_err;
    logic             dr1_meta, dr1_sync;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift, rx_data;
    logic [DIV_W-1:0] clkdiv;
    logic [7:0]       ctrl_word, status_word, read_mux;
    logic             wr, rd, wr_data, wr_control, wr_status, wr_clkdiv, rd_data, start, tick;

    assign wr         = bus.chipselect && !bus.write_n;
    assign rd         = bus.chipselect && !bus.read_n;
    assign wr_data    = wr && (bus.address == ADDR_DATA);
    assign wr_control = wr && (bus.address == ADDR_CONTROL);
    assign wr_status  = wr && (bus.address == ADDR_STATUS);
    assign wr_clkdiv  = wr && (bus.address == ADDR_CLKDIV);
    assign rd_data    = rd && (bus.address == ADDR_DATA);
    assign start      = wr_data && !busy;

    nrf2401_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start),
        .run      ((state == S_LOW) || (state == S_HIGH)),
        .load_val (clkdiv),
        .tick     (tick)
    );

    // The line is ours whenever the direction is TX, so the last bit keeps being driven while idle.
    assign rf_data = (dir == DIR_TX) ? shift[7] : 1'bz;
    assign irq     = done && irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            rf_clk  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LOW;
                        busy    <= 1'b1;
                        bit_cnt <= 3'd7;
                        if (dir == DIR_TX)
                            shift <= bus.writedata;
                    end
                end
                S_LOW: begin
                    if (tick) begin
                        state  <= S_HIGH;
                        rf_clk <= 1'b1;
                        if (dir == DIR_RX)
                            shift <= {shift[6:0], rf_data};
                    end
                end
                S_HIGH: begin
                    if (tick) begin
                        rf_clk <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_LOW;
                            bit_cnt <= bit_cnt - 3'd1;
                            if (dir == DIR_TX)
                                shift <= {shift[6:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Software clears come first so that a hardware set in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir      <= DIR_RX;
            rf_cs    <= 1'b0;
            rf_ce    <= 1'b0;
            irq_en   <= 1'b0;
            clkdiv   <= DIV_RESET;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            if (wr_control) begin
                rf_cs  <= bus.writedata[CTRL_CS];
                rf_ce  <= bus.writedata[CTRL_CE];
                irq_en <= bus.writedata[CTRL_IRQ_EN];
                if (!busy)
                    dir <= bus.writedata[CTRL_DIR];
            end
            if (wr_clkdiv)
                clkdiv <= bus.writedata[DIV_W-1:0];
            if (wr_status) begin
                if (bus.writedata[ST_DONE])    done    <= 1'b0;
                if (bus.writedata[ST_OVERRUN]) overrun <= 1'b0;
                if (bus.writedata[ST_WR_ERR])  wr_err  <= 1'b0;
            end
            if (wr_data && busy)
                wr_err <= 1'b1;
            if (rd_data)
                rx_valid <= 1'b0;
            if (state == S_DONE) begin
                done <= 1'b1;
                if (dir == DIR_RX) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    if (rx_valid)
                        overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrl_word              = 8'h00;
        ctrl_word[CTRL_DIR]    = dir;
        ctrl_word[CTRL_CS]     = rf_cs;
        ctrl_word[CTRL_CE]     = rf_ce;
        ctrl_word[CTRL_IRQ_EN] = irq_en;

        status_word              = 8'h00;
        status_word[ST_BUSY]     = busy;
        status_word[ST_RX_VALID] = rx_valid;
        status_word[ST_DONE]     = done;
        status_word[ST_OVERRUN]  = overrun;
        status_word[ST_WR_ERR]   = wr_err;
        status_word[ST_DR1]      = dr1_sync;

        read_mux = 8'h00;
        case (bus.address)
            ADDR_DATA:    read_mux = rx_data;
            ADDR_CONTROL: read_mux = ctrl_word;
            ADDR_STATUS:  read_mux = status_word;
            ADDR_CLKDIV:  read_mux = 8'(clkdiv);
            default:      read_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 8'h00;
            dr1_meta     <= 1'b0;
            dr1_sync     <= 1'b0;
        end else begin
            bus.readdata <= read_mux;
            dr1_meta     <= rf_dr1;
            dr1_sync     <= dr1_meta;
        end
    end

endmodule

// File: tb/tb_nrf2401_spi_shifter.sv
// Randomised self-checking bench for nrf2401_spi_shifter with a register-level radio/CPU model.
module tb_nrf2401_spi_shifter;

    localparam logic [1:0] A_DATA = 2'd0, A_CONTROL = 2'd1, A_STATUS = 2'd2, A_CLKDIV = 2'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rf_clk, rf_cs, rf_ce, irq;
    logic rf_dr1 = 1'b0;
    wire  rf_data;

    nrf2401_spi_shifter_if bus ();

    nrf2401_spi_shifter #(.DIV_W(8), .DIV_RESET(8'd4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .rf_data (rf_data),
        .rf_clk  (rf_clk),
        .rf_cs   (rf_cs),
        .rf_ce   (rf_ce),
        .rf_dr1  (rf_dr1),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // A released DATA line floats high, so it reads 1 when nobody drives it.
    pullup (rf_data);

    logic       tb_drv_en = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_idx = 0;
    assign rf_data = tb_drv_en ? ((rx_idx < 8) ? rx_byte[7 - rx_idx] : 1'b0) : 1'bz;

    int   cyc = 0;
    logic seen_bits[$];
    int   seen_cyc[$];

    always @(posedge clk) cyc++;

    // Radio-side view: log each bit seen at a CLK1 rise, then present the next RX bit.
    always @(posedge rf_clk) begin
        #1;
        seen_bits.push_back(rf_data);
        seen_cyc.push_back(cyc);
        rx_idx = rx_idx + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    bit         m_done, m_rxv, m_ovr, m_werr, m_dr1;
    logic [7:0] m_rxdata;

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = 8'h00;
        if (m_rxv)  s = s + 8'd2;
        if (m_done) s = s + 8'd4;
        if (m_ovr)  s = s + 8'd8;
        if (m_werr) s = s + 8'd16;
        if (m_dr1)  s = s + 8'd32;
        return s;
    endfunction

    task automatic model_clear();
        m_done = 0; m_rxv = 0; m_ovr = 0; m_werr = 0; m_dr1 = 0; m_rxdata = 8'h00;
    endtask

    task automatic model_complete(input bit rx, input logic [7:0] b);
        m_done = 1;
        if (rx) begin
            if (m_rxv) m_ovr = 1;
            m_rxv    = 1;
            m_rxdata = b;
        end
    endtask

    function automatic logic [7:0] seen_byte();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8 && i < seen_bits.size(); i++) v = {v[6:0], seen_bits[i]};
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (rf_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_clk: got %b expected 0", rf_clk); end
        vectors++; if ({rf_cs, rf_ce, irq} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_pins: got cs/ce/irq %b expected 000", {rf_cs, rf_ce, irq}); end
        vectors++; if (rf_data !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rf_data_released: got %b expected pulled-up 1", rf_data); end
        vectors++; if (bus.readdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_readdata: got %h expected 00", bus.readdata); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
        bus_read(A_CONTROL, r);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL reset_control: got %h expected 01", r); end
        bus_read(A_STATUS, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_status: got %h expected 00", r); end
        bus_read(A_CLKDIV, r);
        vectors++; if (r !== 8'h04) begin miscompares++; $display("[TB] FAIL reset_clkdiv: got %h expected 04", r); end
        bus_read(A_DATA, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", r); end
    endtask

    task automatic test_tx();
        logic [7:0] b, r;
        int div, start, done_at, bad;
        bus_write(A_STATUS, 8'h1C);
        m_done = 0; m_ovr = 0; m_werr = 0;
        bus_write(A_CONTROL, 8'h0A);
        vectors++; if ({rf_cs, rf_ce} !== 2'b10) begin miscompares++; $display("[TB] FAIL tx_cs_ce: got %b expected 10", {rf_cs, rf_ce}); end
        for (int t = 0; t < 6; t++) begin
            div = (t == 0) ? 1 : int'($urandom_range(0, 3));
            b   = (t == 0) ? 8'hA5 : 8'($urandom);
            bus_write(A_CLKDIV, 8'(div));
            seen_bits.delete(); seen_cyc.delete();
            bus_write(A_DATA, b);
            start   = cyc;
            done_at = -1;
            for (int n = 1; n <= 16 * (div + 1) + 20; n++) begin
                @(posedge clk); #1;
                if (irq === 1'b1) begin done_at = cyc - start; break; end
            end
            vectors++; if (done_at != 16 * (div + 1) + 1) begin miscompares++; $display("[TB] FAIL tx_done_latency: got %0d cycles expected %0d (div %0d)", done_at, 16 * (div + 1) + 1, div); end
            vectors++; if (seen_bits.size() != 8 || seen_byte() !== b) begin miscompares++; $display("[TB] FAIL tx_bits: got %h (%0d bits) expected %h", seen_byte(), seen_bits.size(), b); end
            bad = 0;
            for (int i = 1; i < seen_cyc.size(); i++) if (seen_cyc[i] - seen_cyc[i-1] != 2 * (div + 1)) bad++;
            vectors++; if (bad != 0 || seen_cyc.size() == 0 || seen_cyc[0] - start != div + 1) begin miscompares++; $display("[TB] FAIL tx_clk_timing: got %0d bad periods, first rise %0d expected period %0d first %0d", bad, (seen_cyc.size() > 0) ? seen_cyc[0] - start : -1, 2 * (div + 1), div + 1); end
            vectors++; if (rf_data !== b[0] || rf_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_idle_hold: got data %b clk %b expected data %b clk 0", rf_data, rf_clk, b[0]); end
            model_complete(0, b);
            bus_read(A_STATUS, r);
            vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL tx_status: got %h expected %h", r, exp_status()); end
            bus_write(A_STATUS, 8'h04);
            m_done = 0;
            vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_irq_clear: got %b expected 0", irq); end
        end
    endtask

    task automatic test_rx();
        logic [7:0] b, x, r;
        bus_write(A_CONTROL, 8'h03);
        tb_drv_en = 1'b1;
        bus_write(A_CLKDIV, 8'h00);
        bus_write(A_STATUS, 8'h1C);
        bus_read(A_DATA, r);
        m_done = 0; m_ovr = 0; m_werr = 0; m_rxv = 0;
        for (int t = 0; t < 2; t++) begin
            b = (t == 0) ? 8'h3C : 8'($urandom);
            rx_byte = b; rx_idx = 0;
            bus_write(A_DATA, 8'($urandom));
            idle(18);
            model_complete(1, b);
            bus_read(A_STATUS, r);
            vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL rx_status_%0d: got %h expected %h", t, r, exp_status()); end
        end
        bus_read(A_DATA, r);
        vectors++; if (r !== m_rxdata) begin miscompares++; $display("[TB] FAIL rx_data: got %h expected %h", r, m_rxdata); end
        m_rxv = 0;
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL rx_after_read: got %h expected %h", r, exp_status()); end
        bus_write(A_STATUS, 8'h1C);
        m_done = 0; m_ovr = 0;
        x = 8'($urandom); rx_byte = x; rx_idx = 0;
        bus_write(A_DATA, 8'h00);
        idle(18);
        model_complete(1, x);
        b = ~x; rx_byte = b; rx_idx = 0;
        bus_write(A_DATA, 8'h00);
        idle(16);
        bus_read(A_DATA, r);
        vectors++; if (r !== x) begin miscompares++; $display("[TB] FAIL rx_read_in_done: got %h expected old byte %h", r, x); end
        model_complete(1, b);
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL rx_done_race_status: got %h expected %h", r, exp_status()); end
        bus_read(A_DATA, r);
        vectors++; if (r !== b) begin miscompares++; $display("[TB] FAIL rx_second_byte: got %h expected %h", r, b); end
        m_rxv = 0;
        tb_drv_en = 1'b0;
    endtask

    task automatic test_wr_err();
        logic [7:0] b, r;
        bus_write(A_CONTROL, 8'h0A);
        bus_write(A_CLKDIV, 8'h02);
        bus_write(A_STATUS, 8'h1C);
        m_done = 0; m_ovr = 0; m_werr = 0;
        b = 8'($urandom);
        seen_bits.delete(); seen_cyc.delete();
        bus_write(A_DATA, b);
        bus_read(A_STATUS, r);
        vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_after_start: got %b expected 1", r[0]); end
        bus_write(A_DATA, ~b);
        m_werr = 1;
        bus_write(A_CONTROL, 8'h05);
        vectors++; if ({rf_cs, rf_ce} !== 2'b01) begin miscompares++; $display("[TB] FAIL busy_ctrl_update: got cs/ce %b expected 01", {rf_cs, rf_ce}); end
        vectors++; if (rf_data !== b[7]) begin miscompares++; $display("[TB] FAIL busy_dir_ignored: got %b expected %b", rf_data, b[7]); end
        idle(60);
        vectors++; if (seen_bits.size() != 8 || seen_byte() !== b) begin miscompares++; $display("[TB] FAIL wr_err_transfer: got %h (%0d bits) expected %h", seen_byte(), seen_bits.size(), b); end
        model_complete(0, b);
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL wr_err_status: got %h expected %h", r, exp_status()); end
        bus_read(A_CONTROL, r);
        vectors++; if (r !== 8'h04) begin miscompares++; $display("[TB] FAIL wr_err_control: got %h expected 04", r); end
        bus_write(A_STATUS, 8'h10);
        m_werr = 0;
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL wr_err_clear: got %h expected %h", r, exp_status()); end
    endtask

    task automatic test_irq();
        logic [7:0] r;
        bus_write(A_CONTROL, 8'h0A);
        bus_write(A_CLKDIV, 8'h00);
        bus_write(A_STATUS, 8'h1C);
        m_done = 0; m_ovr = 0; m_werr = 0;
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
        bus_write(A_DATA, 8'($urandom));
        idle(20);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_rise: got %b expected 1", irq); end
        bus_write(A_STATUS, 8'h04);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
        bus_write(A_DATA, 8'($urandom));
        idle(16);
        bus_write(A_STATUS, 8'h04);
        m_done = 1;
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_clear_race: got %b expected 1", irq); end
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL done_clear_race: got %h expected %h", r, exp_status()); end
        bus_write(A_CONTROL, 8'h02);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_dr1();
        logic [7:0] r;
        rf_dr1 = 1'b1; m_dr1 = 1;
        idle(3);
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL dr1_high: got %h expected %h", r, exp_status()); end
        rf_dr1 = 1'b0; m_dr1 = 0;
        idle(3);
        bus_read(A_STATUS, r);
        vectors++; if (r !== exp_status()) begin miscompares++; $display("[TB] FAIL dr1_low: got %h expected %h", r, exp_status()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        bit reached;
        bus_write(A_CONTROL, 8'h0A);
        bus_write(A_CLKDIV, 8'h01);
        seen_bits.delete(); seen_cyc.delete();
        bus_write(A_DATA, 8'($urandom));
        reached = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (seen_bits.size() >= 4) begin reached = 1; break; end
        end
        vectors++; if (!reached) begin miscompares++; $display("[TB] FAIL reset_mid_reach: got %0d bits expected 4 within bound", seen_bits.size()); end
        vectors++; if (rf_clk !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mid_pre_clk: got %b expected 1", rf_clk); end
        reset_n = 1'b0;
        #1;
        vectors++; if (rf_clk !== 1'b0 || irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_pins: got clk %b irq %b expected 0 0", rf_clk, irq); end
        vectors++; if (rf_data !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mid_released: got %b expected pulled-up 1", rf_data); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();
        bus_read(A_STATUS, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mid_status: got %h expected 00", r); end
        bus_read(A_CLKDIV, r);
        vectors++; if (r !== 8'h04) begin miscompares++; $display("[TB] FAIL reset_mid_clkdiv: got %h expected 04", r); end
        idle(40);
        bus_read(A_STATUS, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mid_no_done: got %h expected 00", r); end
    endtask

    initial begin
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1; bus.writedata = 8'h00;
        model_clear();
        test_reset();
        test_tx();
        test_rx();
        test_wr_err();
        test_irq();
        test_dr1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/nrf2401_spi_shifter.md
# nrf2401_spi_shifter

Avalon-MM slave that sequences the single-wire bidirectional serial interface of the nRF2401 radio: it drives CLK1, CS and CE, and shifts bytes MSB-first out of or into the shared DATA line. It replaces bit-banged PIO access to the data and clock pins. The CPU starts each byte with one register write and gets a completion flag and interrupt. The block sits on the system Avalon bus beside the other PIO slaves and owns the radio pins outright.

## Interface
- DIV_W, 8, width of the clock-divider register
- DIV_RESET, 4, reset value of CLKDIV

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select: 0 DATA, 1 CONTROL, 2 STATUS, 3 CLKDIV
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe; used only for the DATA read side effect
- writedata  in  8  write data (CLKDIV uses low DIV_W bits)
- readdata  out  8  registered read data, one-cycle latency
- rf_data  inout  1  radio DATA; driven only in TX direction, otherwise Z
- rf_clk  out  1  radio CLK1
- rf_cs  out  1  radio CS, direct from CONTROL
- rf_ce  out  1  radio CE, direct from CONTROL
- rf_dr1  in  1  radio data-ready; asynchronous, two-flop synchronised
- irq  out  1  level interrupt = STATUS.done & CONTROL.irq_en

## Operation
- CONTROL fields:
  - bit0 dir: 0 TX, 1 RX; reset 1
  - bit1 cs, bit2 ce, bit3 irq_en; all reset 0
  - A write while busy updates cs, ce and irq_en immediately. The dir bit of that write is ignored.
- STATUS fields (read):
  - bit0 busy, bit1 rx_valid, bit2 done, bit3 overrun, bit4 wr_err, bit5 dr1_sync
- STATUS write: write-1-to-clear for bits 2–4. Other bits are ignored.
- DATA write while idle starts a transfer:
  - TX: writedata is loaded into the shift register.
  - RX: writedata is ignored.
  - CLKDIV is latched at start, so a CLKDIV change takes effect on the next transfer.
- DATA write while busy is dropped and sets wr_err.
- DATA read returns the RX byte and clears rx_valid.
- rf_data output enable = (dir == TX). In TX, rf_data holds the current shift-register MSB, and the last bit stays driven when idle.
- FSM states IDLE → LOW → HIGH → (LOW | DONE) → IDLE:
  - LOW: rf_clk=0. In TX, the next bit is presented at entry.
  - HIGH: rf_clk=1. In RX, rf_data is sampled into the LSB on entry.
  - HIGH goes to LOW while bits remain. After the 8th HIGH it goes to DONE.
  - DONE lasts one cycle: rf_clk=0, done set, busy cleared at exit.
  - In RX, DONE also copies the byte to the RX register and sets rx_valid. If rx_valid was already set, overrun is also set.
- Bit counter is 3 bits, counting 7 down to 0.

## Timing
- Each LOW/HIGH phase lasts (div+1) clk cycles. div=0 gives rf_clk = clk/2.
- Byte duration is 16·(div+1)+1 cycles, from the write edge to done set.
- busy reads 1 from the cycle after the start write through the DONE cycle.
- Reset values: readdata 0, rf_clk 0, rf_cs 0, rf_ce 0, irq 0, rf_data Z, STATUS 0, CLKDIV DIV_RESET.
- Reset asserted mid-transfer aborts immediately to reset values. No done flag is produced.
- Simultaneous events: a hardware set beats a software clear of done, overrun or rx_valid. A DATA read in the DONE cycle of an RX transfer returns the old byte, and rx_valid stays 1.
- irq follows done combinationally through one AND, so it is high in the cycle after DONE.

## Structure
- Shared package `nrf2401_pkg` holds:
  - register address constants
  - STATUS/CONTROL bit indices
  - FSM state enum
- Sub-module `nrf2401_clk_div` is a loadable down-counter producing a one-cycle phase tick. Everything else stays in the top level.

## Test plan
- Reset values: reset, then read all registers → CONTROL=0x01, STATUS=0x00, CLKDIV=0x04; rf_data=Z.
- TX at div=1: write CONTROL=0x02, then DATA=0xA5.
  - rf_data shows 1,0,1,0,0,1,0,1, each valid at an rf_clk rise.
  - rf_clk period is 4 cycles.
  - done is set 33 cycles after the write.
- RX at div=0: the model drives 0x3C on rf_data. Write DATA → RXDATA=0x3C, rx_valid=1. A second RX without a read → overrun=1.
- Write DATA while busy → wr_err=1 and the transfer in progress is unchanged. Writing STATUS=0x10 clears wr_err.
- irq_en=1: irq rises after DONE. Writing STATUS=0x04 clears irq. A clear in the same cycle as a new DONE leaves done=1.
- Assert reset_n mid-byte (bit 4) → rf_clk=0 immediately, busy=0, done=0.
